// File: rtl/ochecker.sv
// Pattern-RAM checker: reads DEPTH entries, one every two cycles, and compares each
// against a 16-bit Fibonacci LFSR sequence that starts at SEED.
module ochecker #(
  parameter logic [15:0] SEED  = 16'hBEEF,
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic [4:0]  first_err_addr
);

  typedef enum logic [1:0] {StIdle, StReq, StCmp, StDone} state_e;

  localparam logic [4:0] LastAddr = 5'(DEPTH - 1);

  state_e      state_q;
  logic [4:0]  addr_q;
  logic [15:0] lfsr_q;
  logic        rd_en_q;
  logic [4:0]  rd_addr_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [5:0]  err_count_q;
  logic [4:0]  first_err_addr_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      addr_q           <= '0;
      lfsr_q           <= SEED;
      rd_en_q          <= 1'b0;
      rd_addr_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_q           <= SEED;
            addr_q           <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            pass_q           <= 1'b0;
            rd_en_q          <= 1'b1;
            rd_addr_q        <= '0;
            busy_q           <= 1'b1;
            state_q          <= StReq;
          end
        end
        StReq: state_q <= StCmp;
        StCmp: begin
          if (rd_data != lfsr_q) begin
            err_count_q <= err_count_q + 6'd1;
            if (err_count_q == '0) first_err_addr_q <= addr_q;
          end
          lfsr_q <= lfsr_step(lfsr_q);
          if (addr_q == LastAddr) begin
            addr_q  <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            addr_q    <= addr_q + 5'd1;
            rd_addr_q <= addr_q + 5'd1;
            rd_en_q   <= 1'b1;
            state_q   <= StReq;
          end
        end
        StDone: begin
          // err_count is final here: the last compare landed on the edge into DONE
          pass_q  <= (err_count_q == '0);
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule
